page_stream_fifo: RTL and testbench

// - Elastic buffer on the user-side stream of a page, between leaf_interface and the HLS user_kernel.
//   - Sits on dout_leaf_interface2user/vld/ack or din_leaf_user2interface/vld/ack.
//   - One instance per port.
// - First-word-fall-through FIFO with HLS ap_vld/ap_ack handshakes on both sides.
// - Decouples kernel stalls from interface credit flow and exposes occupancy for debug/freespace tuning.

---
 rtl/page_stream_pkg.sv | 18 +
 rtl/page_stream_fifo_if.sv | 27 ++
 rtl/page_fifo_mem.sv | 23 ++
 rtl/page_stream_fifo.sv | 88 ++++++++
 tb/tb_page_stream_fifo.sv | 138 +++++++++++++
 5 files changed

// File: rtl/page_stream_pkg.sv
// Shared types and helpers for the page stream FIFO.
package page_stream_pkg;

  localparam int unsigned DEFAULT_PAYLOAD_BITS = 32;

  typedef logic [DEFAULT_PAYLOAD_BITS-1:0] payload_t;

  // Ceiling log2; used only at elaboration to sanity-check DEPTH_BITS.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/page_stream_fifo_if.sv
// ap_vld/ap_ack stream bundle: producer-to-FIFO and FIFO-to-consumer handshakes.
interface page_stream_fifo_if
  import page_stream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS
);

  logic [PAYLOAD_BITS-1:0] din;
  logic                    din_vld;
  logic                    din_ack;
  logic [PAYLOAD_BITS-1:0] dout;
  logic                    dout_vld;
  logic                    dout_ack;

  // Environment side: drives the producer and consumer halves.
  modport master (
    output din, din_vld, dout_ack,
    input  din_ack, dout, dout_vld
  );

  // FIFO side.
  modport slave (
    input  din, din_vld, dout_ack,
    output din_ack, dout, dout_vld
  );

endinterface

// File: rtl/page_fifo_mem.sv
// Simple dual-port LUTRAM: synchronous write, asynchronous read.
module page_fifo_mem #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned DEPTH_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_BITS-1:0]   waddr,
  input  logic [PAYLOAD_BITS-1:0] wdata,
  input  logic [DEPTH_BITS-1:0]   raddr,
  output logic [PAYLOAD_BITS-1:0] rdata
);

  logic [PAYLOAD_BITS-1:0] mem [2**DEPTH_BITS];

  // Write port; contents are never cleared, reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/page_stream_fifo.sv
// First-word-fall-through elastic buffer between leaf_interface and user_kernel.
module page_stream_fifo
  import page_stream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = DEFAULT_PAYLOAD_BITS,
  parameter int unsigned DEPTH_BITS      = 4,
  parameter int unsigned ALMOST_FULL_GAP = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  page_stream_fifo_if.slave     s,
  output logic [DEPTH_BITS:0]   count,
  output logic                  almost_full,
  output logic [31:0]           xfer_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FullLevel  = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AfullLevel = (DEPTH_BITS + 1)'(DEPTH - ALMOST_FULL_GAP);

  if (ALMOST_FULL_GAP >= DEPTH) begin : g_bad_gap
    $error("ALMOST_FULL_GAP must be smaller than the FIFO depth");
  end
  if (DEPTH_BITS == 0 || clog2(DEPTH) != DEPTH_BITS) begin : g_bad_depth
    $error("DEPTH_BITS out of range");
  end

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [31:0]           xfer_cnt_q, xfer_cnt_d;
  logic                  push, pop;

  // Flags come only from registered count, so there is no din->dout or ack->ack path.
  always_comb begin
    s.din_ack   = (count_q != FullLevel);
    s.dout_vld  = (count_q != '0);
    almost_full = (count_q >= AfullLevel);
    push        = s.din_vld && s.din_ack;
    pop         = s.dout_vld && s.dout_ack;
  end

  // Pointer, occupancy and delivered-word bookkeeping; pointers wrap naturally mod DEPTH.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    end
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // State registers with synchronous reset; a push/pop in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  page_fifo_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH_BITS   (DEPTH_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr_q),
    .wdata (s.din),
    .raddr (rd_ptr_q),
    .rdata (s.dout)
  );

  assign count    = count_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_page_stream_fifo.sv
// Scoreboard bench for page_stream_fifo: a reference queue tracks accepted words.
module tb_page_stream_fifo;
  import page_stream_pkg::*;

  localparam int unsigned Depth = 16;

  logic        clk;
  logic        reset;
  logic [4:0]  count;
  logic        almost_full;
  logic [31:0] xfer_cnt;

  page_stream_fifo_if #(.PAYLOAD_BITS(32)) sif ();

  page_stream_fifo #(
    .PAYLOAD_BITS    (32),
    .DEPTH_BITS      (4),
    .ALMOST_FULL_GAP (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (sif.slave),
    .count       (count),
    .almost_full (almost_full),
    .xfer_cnt    (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned bad;
  payload_t    sb_q[$];
  int unsigned exp_xfer;
  bit          model_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check settled outputs at negedge, advance model at posedge.
  task automatic cycle(input bit vld, input payload_t data, input bit ack, input bit rst);
    bit exp_push, exp_pop;
    sif.din_vld  = vld;
    sif.din      = data;
    sif.dout_ack = ack;
    reset        = rst;
    @(negedge clk);
    if (model_valid) begin
      check_eq("count", 32'(count), 32'(sb_q.size()));
      check_eq("din_ack", 32'(sif.din_ack), 32'(sb_q.size() != Depth));
      check_eq("dout_vld", 32'(sif.dout_vld), 32'(sb_q.size() != 0));
      check_eq("almost_full", 32'(almost_full), 32'(sb_q.size() >= Depth - 2));
      check_eq("xfer_cnt", xfer_cnt, exp_xfer);
    end
    if (rst) begin
      sb_q.delete();
      exp_xfer    = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_push = vld && (sb_q.size() != Depth);
      exp_pop  = ack && (sb_q.size() != 0);
      if (exp_pop) begin
        check_eq("dout", sif.dout, sb_q.pop_front());
        exp_xfer++;
      end
      if (exp_push) sb_q.push_back(data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    exp_xfer    = 0;
    model_valid = 1'b0;
    sif.din     = '0;
    sif.din_vld = 1'b0;
    sif.dout_ack = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 1);

    // Three pushes with consumer stalled, then drain.
    for (int i = 0; i < 3; i++) cycle(1, payload_t'(32'hA0 + i), 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("head_a0", sif.dout, 32'hA0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Fill to full, one rejected extra word, then drain in order.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, payload_t'(i), 0, 0);
    cycle(1, 32'h99, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check_eq("drained_xfer", xfer_cnt, 32'd16);

    // Streaming through with both sides always ready.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) cycle(1, payload_t'($urandom), 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Full with push and pop together: pop only, push lands next cycle.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(1, payload_t'(32'h100 + i), 0, 0);
    cycle(1, 32'h200, 1, 0);
    cycle(1, 32'h201, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("refilled_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);

    // Empty with dout_ack held high, then a single word passes straight through.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(1, 32'h5EED, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check_eq("single_xfer", xfer_cnt, 32'd1);

    // Reset mid-stream with push and pop pending.
    for (int i = 0; i < 7; i++) cycle(1, payload_t'(32'h300 + i), 0, 0);
    cycle(1, 32'hDEAD, 1, 1);
    cycle(1, 32'h5A5A, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
